// File: rtl/intr_pulse_gen.sv
`default_nettype none
// ============================================================================
// intr_pulse_gen : event strobes -> registered interrupt pulses with minimum
//                  high/low times, saturating event queue and optional ack hold
// Revision       : 1.0
// ============================================================================
module intr_pulse_gen #(
  parameter int C_NUMBER   = 8,
  parameter int C_MIN_HIGH = 16,
  parameter int C_MIN_LOW  = 16,
  parameter int C_PEND_W   = 4,
  parameter int C_WAIT_ACK = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                event_in0,
  input  logic                event_in1,
  input  logic                event_in2,
  input  logic                event_in3,
  input  logic                event_in4,
  input  logic                event_in5,
  input  logic                event_in6,
  input  logic                event_in7,
  input  logic                intr_ack0,
  input  logic                intr_ack1,
  input  logic                intr_ack2,
  input  logic                intr_ack3,
  input  logic                intr_ack4,
  input  logic                intr_ack5,
  input  logic                intr_ack6,
  input  logic                intr_ack7,
  output logic                intr_out0,
  output logic                intr_out1,
  output logic                intr_out2,
  output logic                intr_out3,
  output logic                intr_out4,
  output logic                intr_out5,
  output logic                intr_out6,
  output logic                intr_out7,
  output logic [C_NUMBER-1:0] overflow
);

  localparam int C_MAXHL = (C_MIN_HIGH > C_MIN_LOW) ? C_MIN_HIGH : C_MIN_LOW;
  localparam int C_CW    = (C_MAXHL > 1) ? $clog2(C_MAXHL) : 1;
  localparam logic [C_CW-1:0]     C_HI_LOAD  = C_CW'(C_MIN_HIGH - 1);
  localparam logic [C_CW-1:0]     C_LO_LOAD  = C_CW'(C_MIN_LOW - 1);
  localparam logic [C_PEND_W-1:0] C_PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  logic [7:0] w_ev;
  logic [7:0] w_ack;
  logic [7:0] w_out;

  assign w_ev  = {event_in7, event_in6, event_in5, event_in4,
                  event_in3, event_in2, event_in1, event_in0};
  assign w_ack = {intr_ack7, intr_ack6, intr_ack5, intr_ack4,
                  intr_ack3, intr_ack2, intr_ack1, intr_ack0};

  assign intr_out0 = w_out[0];
  assign intr_out1 = w_out[1];
  assign intr_out2 = w_out[2];
  assign intr_out3 = w_out[3];
  assign intr_out4 = w_out[4];
  assign intr_out5 = w_out[5];
  assign intr_out6 = w_out[6];
  assign intr_out7 = w_out[7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < C_NUMBER) begin : g_act
        state_t              r_state;
        state_t              w_state_nxt;
        logic [C_CW-1:0]     r_cnt;
        logic [C_CW-1:0]     w_cnt_nxt;
        logic [C_PEND_W-1:0] r_pend;
        logic [C_PEND_W-1:0] w_pend_nxt;
        logic                r_out;
        logic                r_ovf;
        logic                w_ovf_set;
        logic                w_start;
        logic                w_inc;
        logic                w_dec;
        logic                w_cnt_zero;
        logic                w_pend_nz;

        assign w_cnt_zero = (r_cnt == '0);
        assign w_pend_nz  = (r_pend != '0);

        always_comb begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
          w_start     = 1'b0;
          w_pend_nxt  = r_pend;
          w_ovf_set   = 1'b0;
          case (r_state)
            S_IDLE: begin
              if (w_ev[gi] || w_pend_nz) w_start = 1'b1;
            end
            S_ASSERT: begin
              if (!w_cnt_zero) begin
                w_cnt_nxt = r_cnt - C_CW'(1);
              end else if (C_WAIT_ACK != 0) begin
                w_state_nxt = S_HOLD;
              end else begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = C_LO_LOAD;
              end
            end
            S_HOLD: begin
              if (w_ack[gi]) begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = C_LO_LOAD;
              end
            end
            default: begin
              if (!w_cnt_zero) begin
                w_cnt_nxt = r_cnt - C_CW'(1);
              end else if (w_ev[gi] || w_pend_nz) begin
                w_start = 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          endcase
          if (w_start) begin
            w_state_nxt = S_ASSERT;
            w_cnt_nxt   = C_HI_LOAD;
          end
          // A pulse starting with an empty queue is the event itself, so it is not queued.
          w_dec = w_start && w_pend_nz;
          w_inc = w_ev[gi] && !(w_start && !w_pend_nz);
          if (w_inc && !w_dec) begin
            if (r_pend == C_PEND_MAX) w_ovf_set = 1'b1;
            else                      w_pend_nxt = r_pend + C_PEND_W'(1);
          end else if (w_dec && !w_inc) begin
            w_pend_nxt = r_pend - C_PEND_W'(1);
          end
        end

        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_out   <= 1'b0;
            r_ovf   <= 1'b0;
          end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_out   <= (w_state_nxt == S_ASSERT) || (w_state_nxt == S_HOLD);
            r_ovf   <= r_ovf | w_ovf_set;
          end
        end

        assign w_out[gi]    = r_out;
        assign overflow[gi] = r_ovf;
      end else begin : g_off
        logic w_unused;
        assign w_unused  = w_ev[gi] ^ w_ack[gi];
        assign w_out[gi] = 1'b0;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_intr_pulse_gen.sv
`default_nettype none
// Bench for intr_pulse_gen: two instances (free-running and ack-hold), table vectors,
// directed corner sequences and random traffic against a timestamp reference model.
module tb_intr_pulse_gen;

  localparam int N0 = 8;
  localparam int N1 = 6;
  localparam int P_N  [2] = '{N0, N1};
  localparam int P_H  [2] = '{16, 16};
  localparam int P_L  [2] = '{16, 16};
  localparam int P_PW [2] = '{4, 2};
  localparam int P_WA [2] = '{0, 1};

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic [7:0] ev0  = '0;
  logic [7:0] ack0 = '0;
  logic [7:0] ev1  = '0;
  logic [7:0] ack1 = '0;
  wire  [7:0] out0;
  wire  [7:0] out1;
  wire  [N0-1:0] ovf0;
  wire  [N1-1:0] ovf1;

  always #5 clk = ~clk;

  intr_pulse_gen #(
    .C_NUMBER(N0), .C_MIN_HIGH(16), .C_MIN_LOW(16), .C_PEND_W(4), .C_WAIT_ACK(0)
  ) u_dut0 (
    .clk(clk), .resetn(resetn),
    .event_in0(ev0[0]), .event_in1(ev0[1]), .event_in2(ev0[2]), .event_in3(ev0[3]),
    .event_in4(ev0[4]), .event_in5(ev0[5]), .event_in6(ev0[6]), .event_in7(ev0[7]),
    .intr_ack0(ack0[0]), .intr_ack1(ack0[1]), .intr_ack2(ack0[2]), .intr_ack3(ack0[3]),
    .intr_ack4(ack0[4]), .intr_ack5(ack0[5]), .intr_ack6(ack0[6]), .intr_ack7(ack0[7]),
    .intr_out0(out0[0]), .intr_out1(out0[1]), .intr_out2(out0[2]), .intr_out3(out0[3]),
    .intr_out4(out0[4]), .intr_out5(out0[5]), .intr_out6(out0[6]), .intr_out7(out0[7]),
    .overflow(ovf0)
  );

  intr_pulse_gen #(
    .C_NUMBER(N1), .C_MIN_HIGH(16), .C_MIN_LOW(16), .C_PEND_W(2), .C_WAIT_ACK(1)
  ) u_dut1 (
    .clk(clk), .resetn(resetn),
    .event_in0(ev1[0]), .event_in1(ev1[1]), .event_in2(ev1[2]), .event_in3(ev1[3]),
    .event_in4(ev1[4]), .event_in5(ev1[5]), .event_in6(ev1[6]), .event_in7(ev1[7]),
    .intr_ack0(ack1[0]), .intr_ack1(ack1[1]), .intr_ack2(ack1[2]), .intr_ack3(ack1[3]),
    .intr_ack4(ack1[4]), .intr_ack5(ack1[5]), .intr_ack6(ack1[6]), .intr_ack7(ack1[7]),
    .intr_out0(out1[0]), .intr_out1(out1[1]), .intr_out2(out1[2]), .intr_out3(out1[3]),
    .intr_out4(out1[4]), .intr_out5(out1[5]), .intr_out6(out1[6]), .intr_out7(out1[7]),
    .overflow(ovf1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each channel remembers when its pulse started, the first
  // edge at which another pulse may start, and how many events are waiting.
  int edge_n;
  int m_pend  [2][8];
  int m_start [2][8];
  int m_free  [2][8];
  bit m_rel   [2][8];
  bit m_ovf   [2][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic void model_reset();
    edge_n = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 8; c++) begin
        m_pend[d][c]  = 0;
        m_start[d][c] = -100000;
        m_free[d][c]  = 0;
        m_rel[d][c]   = 1'b1;
        m_ovf[d][c]   = 1'b0;
      end
  endfunction

  function automatic void model_edge(int d, int c, bit ev, bit ack);
    int pmax;
    pmax = (1 << P_PW[d]) - 1;
    if (c >= P_N[d]) return;
    if (P_WA[d] != 0 && !m_rel[d][c] && ack && edge_n > m_start[d][c] + P_H[d]) begin
      m_rel[d][c]  = 1'b1;
      m_free[d][c] = edge_n + P_L[d];
    end
    if (edge_n >= m_free[d][c] && (ev || m_pend[d][c] > 0)) begin
      if (m_pend[d][c] > 0 && !ev) m_pend[d][c]--;
      m_start[d][c] = edge_n;
      m_rel[d][c]   = 1'b0;
      m_free[d][c]  = (P_WA[d] != 0) ? 32'h3fffffff : edge_n + P_H[d] + P_L[d];
    end else if (ev) begin
      if (m_pend[d][c] == pmax) m_ovf[d][c] = 1'b1;
      else                      m_pend[d][c]++;
    end
  endfunction

  function automatic bit model_out(int d, int c);
    if (c >= P_N[d]) return 1'b0;
    if (P_WA[d] == 0) return (edge_n - m_start[d][c]) < P_H[d];
    return !m_rel[d][c];
  endfunction

  task automatic step();
    logic [7:0] e0, e1, o0, o1;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      model_edge(0, c, ev0[c], ack0[c]);
      model_edge(1, c, ev1[c], ack1[c]);
    end
    #1;
    for (int c = 0; c < 8; c++) begin
      e0[c] = model_out(0, c);
      e1[c] = model_out(1, c);
      o0[c] = m_ovf[0][c];
      o1[c] = m_ovf[1][c];
    end
    chk("model_out0", {24'd0, out0}, {24'd0, e0});
    chk("model_out1", {24'd0, out1}, {24'd0, e1});
    chk("model_ovf0", {24'd0, ovf0}, {24'd0, o0});
    chk("model_ovf1", {26'd0, ovf1}, {24'd0, o1});
    edge_n++;
  endtask

  task automatic do_reset();
    ev0 = '0; ack0 = '0; ev1 = '0; ack1 = '0;
    resetn = 1'b0;
    #1;
    chk("reset_out0", {24'd0, out0}, 32'd0);
    chk("reset_out1", {24'd0, out1}, 32'd0);
    chk("reset_ovf0", {24'd0, ovf0}, 32'd0);
    chk("reset_ovf1", {26'd0, ovf1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] ev;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  rises;
    bit  prev;
    int  rise_at;

    // Single event on ch0 at edge 10, then three events on ch2 at edges 50/52/54.
    tbl.push_back('{8'h00, 10, 8'h00});
    tbl.push_back('{8'h01,  1, 8'h01});
    tbl.push_back('{8'h00, 15, 8'h01});
    tbl.push_back('{8'h00, 24, 8'h00});
    tbl.push_back('{8'h04,  1, 8'h04});
    tbl.push_back('{8'h00,  1, 8'h04});
    tbl.push_back('{8'h04,  1, 8'h04});
    tbl.push_back('{8'h00,  1, 8'h04});
    tbl.push_back('{8'h04,  1, 8'h04});
    tbl.push_back('{8'h00, 11, 8'h04});
    tbl.push_back('{8'h00, 16, 8'h00});
    tbl.push_back('{8'h00, 16, 8'h04});
    tbl.push_back('{8'h00, 16, 8'h00});
    tbl.push_back('{8'h00, 16, 8'h04});
    tbl.push_back('{8'h00, 20, 8'h00});

    #1;
    do_reset();
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        ev0 = tbl[k].ev;
        step();
        chk("tbl_out", {24'd0, out0}, {24'd0, tbl[k].exp});
        chk("tbl_ovf", {24'd0, ovf0}, 32'd0);
      end
    end
    ev0 = '0;

    // Ack-hold instance: early ack ignored, late ack releases, queued pulse waits out the gap.
    do_reset();
    ev1[0] = 1'b1; step(); ev1[0] = 1'b0;
    repeat (4) step();
    ack1[0] = 1'b1; step(); ack1[0] = 1'b0;
    repeat (4) step();
    ev1[0] = 1'b1; step(); ev1[0] = 1'b0;
    repeat (9) step();
    chk("ack_held_past_min", {31'd0, out1[0]}, 32'd1);
    repeat (20) step();
    ack1[0] = 1'b1; step(); ack1[0] = 1'b0;
    chk("ack_fall", {31'd0, out1[0]}, 32'd0);
    rise_at = -1;
    for (int k = 0; k < 100 && rise_at < 0; k++) begin
      step();
      if (out1[0]) rise_at = edge_n - 1;
    end
    chk("ack_next_start_edge", rise_at, 32'd56);
    repeat (20) step();
    ack1[0] = 1'b1; step(); ack1[0] = 1'b0;
    repeat (20) step();
    chk("ack_idle_after", {31'd0, out1[0]}, 32'd0);

    // Saturation on ch7: 17 consecutive events -> 16 pulses and a sticky overflow.
    do_reset();
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k < 17; k++) begin
      ev0[7] = 1'b1;
      step();
      if (out0[7] && !prev) rises++;
      prev = out0[7];
    end
    ev0[7] = 1'b0;
    chk("sat_overflow_set", {31'd0, ovf0[7]}, 32'd1);
    for (int k = 0; k < 16 * 32 + 64; k++) begin
      step();
      if (out0[7] && !prev) rises++;
      prev = out0[7];
    end
    chk("sat_pulse_count", rises, 32'd16);
    chk("sat_overflow_sticky", {31'd0, ovf0[7]}, 32'd1);

    // Reset in the middle of a pulse with three events queued.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ev0[1] = 1'b1;
      step();
    end
    ev0[1] = 1'b0;
    repeat (4) step();
    chk("pre_rst_high", {31'd0, out0[1]}, 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst_async_drop", {31'd0, out0[1]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    rises = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (out0[1]) rises++;
    end
    chk("rst_discards_queue", rises, 32'd0);

    // Random traffic: sparse phase, then a dense phase that drives the queues into saturation.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 8; c++) begin
        ev0[c]  = ($urandom_range(0, 99) < ((k < 2000) ? 4 : 30));
        ev1[c]  = ($urandom_range(0, 99) < ((k < 2000) ? 4 : 30));
        ack0[c] = ($urandom_range(0, 99) < 10);
        ack1[c] = ($urandom_range(0, 99) < 8);
      end
      step();
    end
    ev0 = '0; ev1 = '0; ack0 = '0; ack1 = '0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
